image_stream_out: RTL and testbench
===================================

# image_stream_out

Reads the binary frame latched by the CCD capture stage and streams it out one pixel per beat, row-major, over a valid/ready handshake to the downstream face-detection logic. It drives the capture stage's `cansend` input, so the two blocks form a request/deliver loop: this block asserts `cansend` while it can accept a new frame, and holds it low while it reads the frame out so the frame buffer stays frozen.

## Interface
Parameters:
- `ROWS`, default 150: frame height, equal to the capture buffer's first dimension.
- `COLS`, default 300: frame width, equal to the capture buffer's second dimension.

Ports (one clock; reset is synchronous and active-high):
- `pixclk`, in, 1: the single clock; all state changes on its rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `dataready`, in, 1: the capture stage reports a complete frame in `image`.
- `image`, in, [0:ROWS-1][0:COLS-1]: binary frame; `image[r][c]` is the pixel at row r, column c.
- `cansend`, out, 1: high means the block is idle and will accept a frame; low while a frame is being read out.
- `out_valid`, out, 1: the beat on the output lines is valid.
- `out_ready`, in, 1: the downstream consumer accepts the beat.
- `out_pixel`, out, 1: the pixel value, `image[out_row][out_col]`.
- `out_row`, out, 8 bits ($clog2(ROWS)): row index of the current beat.
- `out_col`, out, 9 bits ($clog2(COLS)): column index of the current beat.
- `out_sof`, out, 1: the current beat is the first pixel of the frame, (0,0).
- `out_eol`, out, 1: the current beat is the last pixel of its row, col = COLS-1.
- `out_eof`, out, 1: the current beat is the last pixel of the frame, (ROWS-1, COLS-1).
- `frame_done`, out, 1: one-cycle pulse after the last beat of a frame is accepted.
- `frames_sent`, out, 8: count of completed frames; wraps from 255 to 0.

## Operation
- States: IDLE, STREAM, DONE.
- A beat transfers on a clock edge where `out_valid && out_ready` is high.
- `dataready` is registered into `dr_q` every cycle. A new frame is requested only by a rising edge, `dataready && !dr_q`.
- IDLE:
  - `cansend`=1, `out_valid`=0, row and column counters held at 0.
  - A rising edge on `dataready` moves the block to STREAM and drives `cansend` to 0.
- STREAM:
  - `out_valid`=1 and `cansend`=0.
  - `out_pixel` is a combinational read of `image` at the registered row/column counters. `image` must stay stable while `cansend`=0; the capture stage guarantees this.
  - On each transfer the column counter increments. When column = COLS-1 it wraps to 0 and the row counter increments.
  - The transfer with `out_eof`=1 moves the block to DONE; the counters reset to 0 and `frames_sent` increments.
  - While `out_ready` is low, every output is held unchanged.
  - `dataready` activity during STREAM is ignored, and any rising edge in that window is discarded.
- DONE: for exactly one cycle, `frame_done`=1, `out_valid`=0, `cansend`=0; then the block returns to IDLE.
- `out_sof`, `out_eol` and `out_eof` are decoded from the counters and are gated by `out_valid`, so they read 0 outside STREAM.
- Arithmetic: the counters are unsigned and never exceed ROWS-1 and COLS-1, so there is no overflow. `frames_sent` is modulo 256.
- Reset, including reset during STREAM: on the next edge the block enters IDLE.
  - `cansend`=1.
  - `out_valid`, `frame_done`, `frames_sent`, the counters and `dr_q` are all 0.
  - A partially sent frame is abandoned with no `out_eof` and no `frame_done`.
- Because `dr_q` resets to 0, a `dataready` level that is already high when reset is released counts as a rising edge and starts a frame.

## Timing
- The rising edge of `dataready` is sampled at edge N. From edge N+1: state STREAM, `out_valid`=1, `cansend`=0, (row,col)=(0,0), `out_sof`=1.
- With `out_ready` held high, throughput is 1 pixel per cycle, so a frame takes ROWS*COLS = 45000 cycles.
- The last beat is accepted at edge E.
  - At E+1: DONE, `frame_done`=1, `out_valid`=0, `frames_sent` already incremented.
  - At E+2: IDLE, `cansend`=1.
- The earliest next frame start is the edge after a new rising edge of `dataready` is observed in IDLE.
- All outputs are registered or decoded from registered state. The only combinational path is from `image` to `out_pixel`.

## Test plan
- Reset, then `image` set to all ones with `dataready` held 0 → `cansend`=1, `out_valid`=0, `frames_sent`=0 for 20 cycles.
- Checkerboard image (`image[r][c]` = (r+c)&1), rising edge on `dataready`, `out_ready`=1 → 45000 beats with correct pixels.
  - `out_sof` only at (0,0); `out_eol` on 150 beats; `out_eof` at (149,299).
  - `frame_done` at E+1, `cansend`=1 at E+2, `frames_sent`=1.
- Same frame, `out_ready` toggled pseudo-randomly → identical beat sequence, and outputs held stable on every stalled cycle.
- `dataready` held high after frame 1 → no second frame; drop it and raise it again → a second frame is sent and `frames_sent`=2.
- `RESET` pulsed at beat (10,17) → next cycle IDLE, `cansend`=1, counters 0, no `frame_done`; a new `dataready` edge restarts the frame at (0,0).
- 256 frames sent back-to-back → `frames_sent` wraps to 0.

Source files
------------

// File: rtl/image_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : image_stream_out
// Brief    : Streams a captured binary frame out one pixel per beat, row-major,
//            over valid/ready, and requests the next frame from capture.
// Revision : 1.0
// ============================================================================
module image_stream_out #(
    parameter int ROWS = 150,
    parameter int COLS = 300
) (
    input  logic                     pixclk,
    input  logic                     RESET,
    input  logic                     dataready,
    input  logic                     image [0:ROWS-1][0:COLS-1],
    output logic                     cansend,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_pixel,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic [$clog2(COLS)-1:0]  out_col,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     frame_done,
    output logic [7:0]               frames_sent
);

    localparam int c_RW = $clog2(ROWS);
    localparam int c_CW = $clog2(COLS);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(ROWS - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);
    localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);
    localparam logic [c_CW-1:0] c_COL_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_dr_q;
    logic [c_RW-1:0]   r_row;
    logic [c_CW-1:0]   r_col;
    logic [7:0]        r_frames;
    logic              w_start;
    logic              w_fire;
    logic              w_last_col;
    logic              w_last;

    // Only a fresh rising edge requests a frame; a held-high level does not.
    assign w_start    = dataready && !r_dr_q;
    assign w_fire     = out_valid && out_ready;
    assign w_last_col = (r_col == c_COL_LAST);
    assign w_last     = w_last_col && (r_row == c_ROW_LAST);

    always_comb begin
        w_next     = r_state;
        cansend    = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                cansend = 1'b1;
                if (w_start) begin
                    w_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                if (w_fire && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Counters only move on transfers and return to 0 after the last beat,
    // so they read 0 whenever the block is idle.
    always_ff @(posedge pixclk) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_dr_q   <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_frames <= '0;
        end else begin
            r_state <= w_next;
            r_dr_q  <= dataready;
            if (w_fire) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + c_ROW_ONE;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                end
                if (w_last) begin
                    r_frames <= r_frames + 8'd1;
                end
            end
        end
    end

    assign out_pixel   = image[r_row][r_col];
    assign out_row     = r_row;
    assign out_col     = r_col;
    assign out_sof     = out_valid && (r_row == '0) && (r_col == '0);
    assign out_eol     = out_valid && w_last_col;
    assign out_eof     = out_valid && w_last;
    assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_image_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_stream_out
// Brief    : Directed self-checking bench for image_stream_out on a small frame.
// Revision : 1.0
// ============================================================================
module tb_image_stream_out;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    logic          pixclk;
    logic          RESET;
    logic          dataready;
    logic          image [0:ROWS-1][0:COLS-1];
    logic          cansend;
    logic          out_valid;
    logic          out_ready;
    logic          out_pixel;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          frame_done;
    logic [7:0]    frames_sent;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    image_stream_out #(.ROWS(ROWS), .COLS(COLS)) dut (
        .pixclk      (pixclk),
        .RESET       (RESET),
        .dataready   (dataready),
        .image       (image),
        .cansend     (cansend),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        dataready = 1'b0;
        step();
        dataready = 1'b1;
        step();
    endtask

    // Walks one frame with a reference row/col model; entered with the DUT in STREAM.
    task automatic run_frame(input bit rnd);
        int  r = 0;
        int  c = 0;
        int  beats = 0;
        int  cyc = 0;
        bit  last;
        forever begin
            chk("valid",   32'(out_valid), 32'd1);
            chk("cansend", 32'(cansend),   32'd0);
            chk("row",     32'(out_row),   r);
            chk("col",     32'(out_col),   c);
            chk("pixel",   32'(out_pixel), 32'(image[r][c]));
            chk("sof",     32'(out_sof),   32'(r == 0 && c == 0));
            chk("eol",     32'(out_eol),   32'(c == COLS-1));
            chk("eof",     32'(out_eof),   32'(r == ROWS-1 && c == COLS-1));
            chk("fdone_mid", 32'(frame_done), 32'd0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            last = out_ready && (r == ROWS-1) && (c == COLS-1);
            if (out_ready) begin
                beats++;
                if (c == COLS-1) begin
                    c = 0;
                    r = (r == ROWS-1) ? 0 : r + 1;
                end else begin
                    c = c + 1;
                end
            end
            step();
            cyc++;
            if (last) break;
            if (cyc > 20*ROWS*COLS) begin
                chk("frame_timeout", 32'd1, 32'd0);
                return;
            end
        end
        exp_frames = (exp_frames + 1) % 256;
        chk("beats",        beats,             ROWS*COLS);
        chk("done_pulse",   32'(frame_done),   32'd1);
        chk("done_valid",   32'(out_valid),    32'd0);
        chk("done_cansend", 32'(cansend),      32'd0);
        chk("done_sof",     32'(out_sof),      32'd0);
        chk("frames_sent",  32'(frames_sent),  exp_frames);
        step();
        chk("idle_cansend", 32'(cansend),      32'd1);
        chk("idle_done",    32'(frame_done),   32'd0);
        chk("idle_valid",   32'(out_valid),    32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        dataready = 1'b0;
        out_ready = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                image[r][c] = 1'b1;
        step();
        step();
        RESET = 1'b0;

        // Idle with no request.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_cansend", 32'(cansend),     32'd1);
            chk("idle_valid",   32'(out_valid),   32'd0);
            chk("idle_frames",  32'(frames_sent), 32'd0);
            chk("idle_eol",     32'(out_eol),     32'd0);
        end

        // Checkerboard at full throughput.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                image[r][c] = 1'((r + c) & 1);
        start_frame();
        run_frame(1'b0);

        // A held-high request must not start another frame.
        for (int i = 0; i < 10; i++) begin
            chk("held_cansend", 32'(cansend),   32'd1);
            chk("held_valid",   32'(out_valid), 32'd0);
            step();
        end

        // Second frame after re-arming, with random back-pressure.
        image[2][3] = ~image[2][3];
        start_frame();
        run_frame(1'b1);

        // Reset in mid-frame at beat (3,4), request held high through reset.
        start_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 3*COLS + 4; i++) step();
        chk("pre_rst_row", 32'(out_row), 32'd3);
        chk("pre_rst_col", 32'(out_col), 32'd4);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        exp_frames = 0;
        chk("rst_cansend", 32'(cansend),     32'd1);
        chk("rst_valid",   32'(out_valid),   32'd0);
        chk("rst_done",    32'(frame_done),  32'd0);
        chk("rst_row",     32'(out_row),     32'd0);
        chk("rst_col",     32'(out_col),     32'd0);
        chk("rst_frames",  32'(frames_sent), 32'd0);
        // dataready is still high and dr_q was cleared, so this is a new request.
        step();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_sof",   32'(out_sof),   32'd1);
        run_frame(1'b0);

        // 255 more frames bring the count since reset to 256, i.e. wrapped to 0.
        for (int f = 0; f < 255; f++) begin
            start_frame();
            run_frame(1'b0);
        end
        chk("wrap_frames", 32'(frames_sent), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
